// File: rtl/control_fsm_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer: opcodes, FSM states,
// datapath mux encodings and trap causes, used by the datapath and the bench.
package control_fsm_pkg;

  // insn[6:2] major opcodes
  localparam logic [4:0] OP_LOAD     = 5'b00000;
  localparam logic [4:0] OP_MISC_MEM = 5'b00011;
  localparam logic [4:0] OP_ALUIMM   = 5'b00100;
  localparam logic [4:0] OP_AUIPC    = 5'b00101;
  localparam logic [4:0] OP_STORE    = 5'b01000;
  localparam logic [4:0] OP_ALU      = 5'b01100;
  localparam logic [4:0] OP_LUI      = 5'b01101;
  localparam logic [4:0] OP_BRANCH   = 5'b11000;
  localparam logic [4:0] OP_JALR     = 5'b11001;
  localparam logic [4:0] OP_JAL      = 5'b11011;

  localparam logic [1:0] PC_SEL_PC4  = 2'd0;
  localparam logic [1:0] PC_SEL_REL  = 2'd1;
  localparam logic [1:0] PC_SEL_JALR = 2'd2;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [1:0] WB_SEL_IMM  = 2'd3;

  localparam logic [1:0] TRAP_ILLEGAL = 2'd0;
  localparam logic [1:0] TRAP_IMEM_TO = 2'd1;
  localparam logic [1:0] TRAP_DMEM_TO = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_e;

  typedef enum logic [3:0] {
    CLS_NONE, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH,
    CLS_LOAD, CLS_STORE, CLS_ALUIMM, CLS_ALU, CLS_MISC_MEM
  } op_class_e;

  // CLS_NONE marks an opcode the core does not implement.
  function automatic op_class_e classify(input logic [4:0] op);
    case (op)
      OP_LUI:      return CLS_LUI;
      OP_AUIPC:    return CLS_AUIPC;
      OP_JAL:      return CLS_JAL;
      OP_JALR:     return CLS_JALR;
      OP_BRANCH:   return CLS_BRANCH;
      OP_LOAD:     return CLS_LOAD;
      OP_STORE:    return CLS_STORE;
      OP_ALUIMM:   return CLS_ALUIMM;
      OP_ALU:      return CLS_ALU;
      OP_MISC_MEM: return CLS_MISC_MEM;
      default:     return CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Instruction/data memory request handshakes between the sequencer (master)
// and the memory ports (slave).
interface control_fsm_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (output imem_req, dmem_req, dmem_we, input imem_ack, dmem_ack);
  modport slave  (input imem_req, dmem_req, dmem_we, output imem_ack, dmem_ack);
endinterface

// File: rtl/control_fsm_bus_wait_timer.sv
// Counts un-acknowledged bus wait cycles; expire flags the last allowed wait
// cycle so the sequencer can trap instead of waiting forever. TIMEOUT=0 disables.
module control_fsm_bus_wait_timer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expire
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default assignment first, so no branch can leave cnt_d unassigned and infer a latch.
    cnt_d = cnt_q;
    if (clear)      cnt_d = '0;
    else if (count) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire = (TIMEOUT != 0) && count && (cnt_q == LAST);

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with one instruction in
// flight, registered bus requests and a sticky trap on illegal insn or bus timeout.
module control_fsm
  import control_fsm_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   opcode,
  input  logic         invalid,
  input  logic         br_taken,
  control_fsm_if.master bus,
  output logic         ir_we,
  output logic         pc_we,
  output logic [1:0]   pc_sel,
  output logic         alu_a_sel,
  output logic         alu_b_sel,
  output logic         rf_we,
  output logic [1:0]   wb_sel,
  output logic         retire,
  output logic         trap,
  output logic [1:0]   trap_cause
);

  state_e    state_q, state_d;
  op_class_e cls_q, cls_d;
  logic      imem_req_q, imem_req_d;
  logic      dmem_req_q, dmem_req_d;
  logic      dmem_we_q, dmem_we_d;
  logic      trap_q, trap_d;
  logic [1:0] trap_cause_q, trap_cause_d;

  logic acked, waiting, expire;

  // Acks only count while our own registered request is up.
  assign acked   = (imem_req_q & bus.imem_ack) | (dmem_req_q & bus.dmem_ack);
  assign waiting = (imem_req_q | dmem_req_q) & ~acked;

  control_fsm_bus_wait_timer #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (~waiting),
    .count  (waiting),
    .expire (expire)
  );

  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    trap_cause_d = trap_cause_q;
    unique case (state_q)
      ST_FETCH: if (imem_req_q) begin
        if (bus.imem_ack) state_d = ST_DECODE;
        else if (expire) begin
          state_d      = ST_TRAP;
          trap_cause_d = TRAP_IMEM_TO;
        end
      end
      ST_DECODE: begin
        cls_d = classify(opcode);
        if (invalid || cls_d == CLS_NONE) begin
          state_d      = ST_TRAP;
          trap_cause_d = TRAP_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: case (cls_q)
        CLS_BRANCH, CLS_MISC_MEM: state_d = ST_FETCH;
        CLS_LOAD, CLS_STORE:      state_d = ST_MEM;
        default:                  state_d = ST_WB;
      endcase
      ST_MEM: if (dmem_req_q) begin
        if (bus.dmem_ack) begin
          if (cls_q == CLS_STORE) state_d = ST_FETCH;
          else                    state_d = ST_WB;
        end else if (expire) begin
          state_d      = ST_TRAP;
          trap_cause_d = TRAP_DMEM_TO;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
    imem_req_d = (state_d == ST_FETCH);
    dmem_req_d = (state_d == ST_MEM);
    dmem_we_d  = dmem_req_d && (cls_d == CLS_STORE);
    trap_d     = (state_d == ST_TRAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      cls_q        <= CLS_NONE;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      trap_q       <= 1'b0;
      trap_cause_q <= TRAP_ILLEGAL;
    end else begin
      state_q      <= state_d;
      cls_q        <= cls_d;
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      trap_q       <= trap_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  assign bus.imem_req = imem_req_q;
  assign bus.dmem_req = dmem_req_q;
  assign bus.dmem_we  = dmem_we_q;
  assign trap         = trap_q;
  assign trap_cause   = trap_cause_q;

  // Selects stay put from EXEC through WB so the ALU result is stable at write-back.
  always_comb begin
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_SEL_PC4;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WB_SEL_ALU;
    retire    = 1'b0;
    if (state_q inside {ST_EXEC, ST_MEM, ST_WB}) begin
      alu_a_sel = cls_q inside {CLS_AUIPC, CLS_JAL, CLS_BRANCH};
      alu_b_sel = cls_q inside {CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH,
                                CLS_LOAD, CLS_STORE, CLS_ALUIMM};
    end
    case (state_q)
      ST_FETCH: ir_we = imem_req_q & bus.imem_ack;
      ST_EXEC: if (cls_q inside {CLS_BRANCH, CLS_MISC_MEM}) begin
        pc_we  = 1'b1;
        retire = 1'b1;
        if (cls_q == CLS_BRANCH && br_taken) pc_sel = PC_SEL_REL;
      end
      ST_MEM: if (dmem_req_q && bus.dmem_ack && cls_q == CLS_STORE) begin
        pc_we  = 1'b1;
        retire = 1'b1;
      end
      ST_WB: begin
        rf_we  = 1'b1;
        pc_we  = 1'b1;
        retire = 1'b1;
        case (cls_q)
          CLS_LOAD: wb_sel = WB_SEL_LOAD;
          CLS_JAL:  begin wb_sel = WB_SEL_PC4; pc_sel = PC_SEL_REL;  end
          CLS_JALR: begin wb_sel = WB_SEL_PC4; pc_sel = PC_SEL_JALR; end
          CLS_LUI:  wb_sel = WB_SEL_IMM;
          default:  ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
